dec8_rr_arbiter: RTL and testbench
==================================

Name: dec8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-way one-hot select resource among 8 requesters.
- Issues a registered one-hot grant plus its 3-bit index, so downstream logic can drive either a decoded select or an encoded one.
- Sits in front of the 3-to-8 select decode path and owns the sequencing of who drives it: ownership, release, fairness and enable gating.

Parameters:
- N, 8, number of requesters; fixed at 8, present for readability only.
- IDX_W, 3, index width, equal to log2(N).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner. Used only when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  arbiter enable; low suppresses all grants.
- req  in  8  requests; requester i drives bit (7-i), so requester 0 is the MSB.
- done  in  1  current owner releases the resource, sampled only in GRANT.
- gnt  out  8  registered one-hot grant; requester i is bit (7-i); all zeros when nobody owns the resource.
- gnt_idx  out  3  index of the current owner; 0 when gnt is zero.
- gnt_valid  out  1  high exactly when gnt is nonzero.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0.
  - Asserting reset mid-grant drops the grant immediately, with no wait for a clock edge.
- State IDLE:
  - If en=1 and req!=0, pick the first requester with its request set, searching indices ptr, ptr+1, ... ptr+7, wrapping mod 8.
  - On the next edge: gnt/gnt_idx/gnt_valid load the winner, ptr <= winner+1 (mod 8, so 7 wraps to 0), hold_cnt <= 0, state <= GRANT.
  - Otherwise all outputs stay zero.
- Latency: a request sampled in IDLE at edge k appears on gnt after edge k (one cycle).
- State GRANT: release occurs at the next edge if any of the following holds:
  - done=1;
  - the owner's req bit is 0;
  - en=0;
  - the timeout condition (see Optional Feature).
- On release: gnt=0, gnt_idx=0, gnt_valid=0, state <= IDLE. ptr is not changed on release.
- If no release condition holds: hold_cnt increments, saturating at 255, and the grant is held.
- Break-before-make: every handoff includes at least one IDLE cycle with gnt=0. Back-to-back grants to different owners are therefore spaced by 1 cycle minimum.
- Simultaneous events:
  - done together with the owner's req still high: release wins. The owner can re-win later only through normal rotation.
  - done asserted in IDLE: ignored.
  - req changes on non-owner bits during GRANT: no effect until IDLE.
- en=0 in IDLE: no grant is issued, regardless of req.
- Invariant: gnt is always one-hot or zero, and gnt == onehot(gnt_idx) whenever gnt_valid=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt == MAX_HOLD-1 and no other release condition holds, the grant is revoked at the next edge and timeout pulses high for that one cycle (the first IDLE cycle).
  - The owner is thereby held exactly MAX_HOLD cycles.
- Undefined:
  - The grant is held indefinitely until done, owner req drop or en=0.
  - The timeout port is tied to 0 and the hold_cnt compare logic is removed.

Decomposition:
- Shared package dec8_arb_pkg:
  - constants N=8, IDX_W=3;
  - state enum {IDLE, GRANT};
  - function idx2onehot(idx), returning 8'b1000_0000 >> idx, i.e. MSB-first decode.
- One natural sub-module: rr_pick8, purely combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, win_idx[2:0].
  - The top level holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Reset mid-grant: owner 2 granted (gnt=8'h20), assert rst_n=0 mid-cycle -> gnt=8'h00, gnt_valid=0 immediately; after release, req=8'h80 -> gnt=8'h80, idx=0 one cycle later (ptr back to 0).
- Single request: en=1, req=8'h80 -> next cycle gnt=8'h80, gnt_idx=0, gnt_valid=1; pulse done -> gnt=8'h00 next cycle.
- Full rotation: req=8'hFF held, done pulsed each GRANT cycle -> gnt_idx sequence 0,1,2,3,4,5,6,7,0, with one zero-gnt cycle between grants.
- Fairness skip: ptr=3 after granting 2; req=8'h81 (requesters 0 and 7) -> grant idx 7 (gnt=8'h01), then idx 0.
- Enable gating: owner 4 (gnt=8'h08), drop en -> gnt=8'h00 next cycle; req=8'hFF with en=0 -> no grant for 10 cycles.
- ARB_TIMEOUT_EN, MAX_HOLD=16: req=8'h40 held, done=0 -> gnt=8'h40 for exactly 16 cycles, then gnt=0 with timeout=1 for one cycle, then regrant idx 1.

Source files
------------

// File: rtl/dec8_arb_pkg.sv
// Shared constants, state encoding and MSB-first index decode for the 8-way round-robin arbiter.
package dec8_arb_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Requester i maps to bit (N-1-i), so index 0 decodes to the MSB.
  function automatic logic [N-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return N'(8'h80) >> idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority search: first set request at ptr, ptr+1, ... ptr+7 (mod 8).
module rr_pick8
  import dec8_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] bit_pos;

  always_comb begin
    any     = 1'b0;
    win_idx = '0;
    cand    = '0;
    bit_pos = '0;
    for (int k = 0; k < N; k++) begin
      cand    = IDX_W'(ptr + IDX_W'(k));
      bit_pos = IDX_W'(N - 1) - cand;
      if (!any && req[bit_pos]) begin
        any     = 1'b1;
        win_idx = cand;
      end
    end
  end

endmodule

// File: rtl/dec8_rr_arbiter.sv
// Round-robin owner sequencing for the 8-way one-hot select path; break-before-make handoff.
// Optional forced revocation after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module dec8_rr_arbiter
  import dec8_arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned MAX_HOLD = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             release_c;
  logic             expire_c;

  rr_pick8 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .any     (pick_any),
    .win_idx (pick_idx)
  );

  // Voluntary release: owner done, owner request withdrawn, or arbiter disabled.
  assign release_c = done || ((req & gnt_q) == '0) || !en;

`ifdef ARB_TIMEOUT_EN
  assign expire_c = !release_c && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
`else
  assign expire_c = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (en && pick_any) begin
          gnt_d       = idx2onehot(pick_idx);
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          ptr_d       = IDX_W'(pick_idx + IDX_W'(1));
          hold_cnt_d  = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (release_c || expire_c) begin
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          timeout_d   = expire_c;
          state_d     = IDLE;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = CNT_W'(hold_cnt_q + CNT_W'(1));
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_dec8_rr_arbiter.sv
// Directed bench for dec8_rr_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_dec8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  dec8_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_grant(input string tag, input int idx);
    logic [7:0] oh;
    oh = 8'h80 >> idx;
    check_eq({tag, ".gnt"}, 32'(gnt), 32'(oh));
    check_eq({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    check_eq({tag, ".valid"}, 32'(gnt_valid), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".gnt"}, 32'(gnt), 32'd0);
    check_eq({tag, ".idx"}, 32'(gnt_idx), 32'd0);
    check_eq({tag, ".valid"}, 32'(gnt_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    step();
    check_idle("reset");
    check_eq("reset.timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    step();

    // Owner 2, then asynchronous reset mid-grant; ptr must come back to 0.
    en  = 1'b1;
    req = 8'h20;
    step();
    check_grant("own2", 2);
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    step();
    rst_n = 1'b1;
    req   = 8'h80;
    step();
    check_grant("after_rst", 0);

    // Release by done while the owner still requests.
    done = 1'b1;
    step();
    check_idle("done_rel");
    done = 1'b0;
    req  = 8'h00;
    step();

    // Full rotation from ptr=0 with done held: one grant cycle, one idle cycle.
    do_reset();
    req  = 8'hFF;
    done = 1'b1;
    for (int g = 0; g < 9; g++) begin
      step();
      check_grant($sformatf("rot%0d", g), g % 8);
      step();
      check_idle($sformatf("rot_gap%0d", g));
      if (g == 8) begin
        req  = 8'h00;
        done = 1'b0;
      end
    end
    step();
    check_idle("rot_end");

    // ptr=1 here; grant 2 so ptr becomes 3, then 0 and 7 compete.
    req = 8'h20;
    step();
    check_grant("pre_skip", 2);
    done = 1'b1;
    step();
    check_idle("pre_skip_rel");
    req = 8'h81;
    step();
    check_grant("skip7", 7);
    step();
    check_idle("skip_gap");
    step();
    check_grant("skip0", 0);
    req  = 8'h00;
    done = 1'b0;
    step();
    check_idle("skip_end");

    // ptr=1; owner 4, then drop enable.
    req = 8'h08;
    step();
    check_grant("own4", 4);
    en = 1'b0;
    step();
    check_idle("en_drop");
    req = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      step();
      check_eq($sformatf("en_off%0d", c), 32'(gnt), 32'd0);
    end

    // ptr=5; re-enable, non-owner request changes must not disturb owner 5.
    en = 1'b1;
    step();
    check_grant("own5", 5);
    req = 8'h04;
    step();
    check_grant("own5_hold", 5);
    req = 8'h00;
    step();
    check_idle("own5_reqdrop");
    check_eq("no_timeout_on_rel", 32'(timeout), 32'd0);
    done = 1'b1;
    step();
    check_idle("done_in_idle");
    done = 1'b0;

    // ptr=6; requester 1 holds with done low.
    req = 8'h40;
    for (int c = 0; c < 16; c++) begin
      step();
      check_grant($sformatf("hold%0d", c), 1);
      check_eq($sformatf("hold%0d.to", c), 32'(timeout), 32'd0);
    end
    step();
`ifdef ARB_TIMEOUT_EN
    check_idle("expired");
    check_eq("expired.to", 32'(timeout), 32'd1);
    step();
    check_grant("regrant", 1);
    check_eq("regrant.to", 32'(timeout), 32'd0);
`else
    check_grant("hold16", 1);
    check_eq("hold16.to", 32'(timeout), 32'd0);
    step();
    check_grant("hold17", 1);
`endif
    req = 8'h00;
    step();
    check_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
